// File: rtl/hs32_pkg.sv
// HS32 decode-controller shared definitions.
// Prefix codes, legal-prefix ceiling and controller state encoding.
package hs32_pkg;

  localparam logic [3:0] OP_IMM16 = 4'h0;
  localparam logic [3:0] OP_SHIFT = 4'h1;
  localparam logic [3:0] OP_IMM24 = 4'h2;
  localparam logic [3:0] OP_REG   = 4'h3;
  localparam logic [3:0] OP_JUMP  = 4'h4;

  localparam logic [3:0] MAXOP_DEF = OP_JUMP;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  function automatic logic [3:0] op_of(input logic [31:0] w);
    return w[31:28];
  endfunction

endpackage

// File: rtl/hs32_ibuf.sv
// HS32 instruction buffer: DEPTH-entry FIFO.
// Holds storage, read/write pointers and occupancy.
module hs32_ibuf
  import hs32_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   head,
  output logic [CW-1:0] count
);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/hs32_dec_ctl.sv
// HS32 decode controller: buffers fetched words, issues
// legal prefixes to execute, traps on illegal ones.
module hs32_dec_ctl
  import hs32_pkg::*;
#(
  parameter int         DEPTH = 2,
  parameter logic [3:0] MAXOP = MAXOP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instd,
  input  logic        ackd,
  output logic        reqd,
  output logic [31:0] dec_inst,
  output logic        exec_req,
  input  logic        exec_ack,
  input  logic        flush,
  output logic        trap,
  output logic [3:0]  trap_op,
  input  logic        trap_clr,
  output logic [15:0] issued
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e        state_q, state_d;
  logic          trap_q, trap_d;
  logic [3:0]    trap_op_q, trap_op_d;
  logic [15:0]   issued_q, issued_d;

  logic [31:0]   head;
  logic [CW-1:0] count;
  logic [3:0]    op;
  logic          has;
  logic          run;
  logic          push;
  logic          issue;
  logic          trap_hit;
  logic          clr_pop;

  assign op  = op_of(head);
  assign has = (count != '0);
  assign run = !reset && !flush && (state_q == ST_RUN);

  assign reqd     = run && (count < CW'(DEPTH));
  assign exec_req = run && has && (op <= MAXOP);
  assign dec_inst = has ? head : 32'h0;

  assign push     = reqd && ackd;
  assign issue    = exec_req && exec_ack;
  assign trap_hit = run && has && (op > MAXOP);
  // Trap acknowledge retires the offending head without issuing it.
  assign clr_pop  = !flush && (state_q == ST_TRAP) && trap_clr;

  hs32_ibuf #(
    .DEPTH (DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .push  (push),
    .pop   (issue || clr_pop),
    .din   (instd),
    .head  (head),
    .count (count)
  );

  always_comb begin
    state_d   = state_q;
    trap_d    = trap_q;
    trap_op_d = trap_op_q;
    issued_d  = issued_q + {15'h0, issue};
    if (flush) begin
      state_d   = ST_RUN;
      trap_d    = 1'b0;
      trap_op_d = 4'h0;
    end else begin
      unique case (1'b1)
        trap_hit: begin
          state_d   = ST_TRAP;
          trap_d    = 1'b1;
          trap_op_d = op;
        end
        clr_pop: begin
          state_d   = ST_RUN;
          trap_d    = 1'b0;
          trap_op_d = 4'h0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      trap_q    <= 1'b0;
      trap_op_q <= 4'h0;
      issued_q  <= 16'h0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      trap_op_q <= trap_op_d;
      issued_q  <= issued_d;
    end
  end

  assign trap    = trap_q;
  assign trap_op = trap_op_q;
  assign issued  = issued_q;

endmodule

// File: tb/tb_hs32_dec_ctl.sv
// Directed self-checking bench for hs32_dec_ctl.
// Scenario tasks run in sequence with inline checks.
module tb_hs32_dec_ctl;

  logic        clk;
  logic        reset;
  logic [31:0] instd;
  logic        ackd;
  logic        reqd;
  logic [31:0] dec_inst;
  logic        exec_req;
  logic        exec_ack;
  logic        flush;
  logic        trap;
  logic [3:0]  trap_op;
  logic        trap_clr;
  logic [15:0] issued;

  int checks;
  int failures;
  logic [15:0] exp_issued;

  hs32_dec_ctl dut (
    .clk      (clk),
    .reset    (reset),
    .instd    (instd),
    .ackd     (ackd),
    .reqd     (reqd),
    .dec_inst (dec_inst),
    .exec_req (exec_req),
    .exec_ack (exec_ack),
    .flush    (flush),
    .trap     (trap),
    .trap_op  (trap_op),
    .trap_clr (trap_clr),
    .issued   (issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    ackd     = 1'b0;
    exec_ack = 1'b0;
    flush    = 1'b0;
    trap_clr = 1'b0;
    instd    = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    #1;
    checks++;
    if (reqd !== 1'b0) begin
      failures++;
      $display("FAIL rst_reqd got=%0h exp=0", reqd);
    end
    checks++;
    if (exec_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_exec_req got=%0h exp=0", exec_req);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (trap !== 1'b0 || trap_op !== 4'h0) begin
      failures++;
      $display("FAIL rst_trap got=%0h/%0h exp=0/0", trap, trap_op);
    end
    checks++;
    if (issued !== 16'h0) begin
      failures++;
      $display("FAIL rst_issued got=%0h exp=0", issued);
    end
    checks++;
    if (dec_inst !== 32'h0) begin
      failures++;
      $display("FAIL rst_dec_inst got=%0h exp=0", dec_inst);
    end
    checks++;
    if (reqd !== 1'b1 || exec_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_run got=%0h/%0h exp=1/0", reqd, exec_req);
    end
    exp_issued = 16'h0;
  endtask

  task automatic test_stream();
    exec_ack = 1'b1;
    ackd     = 1'b1;
    instd    = 32'h0123_4567;
    #1;
    checks++;
    if (reqd !== 1'b1 || exec_req !== 1'b0) begin
      failures++;
      $display("FAIL str_c0 got=%0h/%0h exp=1/0", reqd, exec_req);
    end
    tick();
    instd = 32'h3ABC_0000;
    #1;
    checks++;
    if (exec_req !== 1'b1 || dec_inst !== 32'h0123_4567) begin
      failures++;
      $display("FAIL str_c1 got=%0h/%0h exp=1/01234567", exec_req, dec_inst);
    end
    tick();
    ackd = 1'b0;
    #1;
    checks++;
    if (exec_req !== 1'b1 || dec_inst !== 32'h3ABC_0000) begin
      failures++;
      $display("FAIL str_c2 got=%0h/%0h exp=1/3abc0000", exec_req, dec_inst);
    end
    tick();
    exec_ack = 1'b0;
    exp_issued = exp_issued + 16'd2;
    #1;
    checks++;
    if (issued !== exp_issued || exec_req !== 1'b0) begin
      failures++;
      $display("FAIL str_done got=%0h/%0h exp=%0h/0", issued, exec_req, exp_issued);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    logic        rq [3];
    w[0] = 32'h1111_0001;
    w[1] = 32'h2222_0002;
    w[2] = 32'h4444_0003;
    rq[0] = 1'b1;
    rq[1] = 1'b1;
    rq[2] = 1'b0;
    exec_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ackd  = 1'b1;
      instd = w[i];
      #1;
      checks++;
      if (reqd !== rq[i]) begin
        failures++;
        $display("FAIL bp_reqd%0d got=%0h exp=%0h", i, reqd, rq[i]);
      end
      tick();
    end
    ackd = 1'b0;
    #1;
    checks++;
    if (reqd !== 1'b0 || dec_inst !== w[0] || exec_req !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got=%0h/%0h/%0h exp=0/%0h/1", reqd, dec_inst, exec_req, w[0]);
    end
    exec_ack = 1'b1;
    tick();
    #1;
    checks++;
    if (dec_inst !== w[1] || reqd !== 1'b1) begin
      failures++;
      $display("FAIL bp_head1 got=%0h/%0h exp=%0h/1", dec_inst, reqd, w[1]);
    end
    tick();
    exec_ack = 1'b0;
    exp_issued = exp_issued + 16'd2;
    #1;
    checks++;
    if (exec_req !== 1'b0 || dec_inst !== 32'h0 || issued !== exp_issued) begin
      failures++;
      $display("FAIL bp_empty got=%0h/%0h/%0h exp=0/0/%0h", exec_req, dec_inst, issued, exp_issued);
    end
  endtask

  task automatic test_trap();
    exec_ack = 1'b1;
    ackd     = 1'b1;
    instd    = 32'h7000_0001;
    tick();
    ackd = 1'b0;
    #1;
    checks++;
    if (exec_req !== 1'b0 || dec_inst !== 32'h7000_0001) begin
      failures++;
      $display("FAIL trap_head got=%0h/%0h exp=0/70000001", exec_req, dec_inst);
    end
    tick();
    ackd  = 1'b1;
    instd = 32'h1000_0005;
    #1;
    checks++;
    if (trap !== 1'b1 || trap_op !== 4'h7) begin
      failures++;
      $display("FAIL trap_set got=%0h/%0h exp=1/7", trap, trap_op);
    end
    checks++;
    if (reqd !== 1'b0 || exec_req !== 1'b0) begin
      failures++;
      $display("FAIL trap_hold got=%0h/%0h exp=0/0", reqd, exec_req);
    end
    tick();
    ackd     = 1'b0;
    trap_clr = 1'b1;
    #1;
    checks++;
    if (trap !== 1'b1 || dec_inst !== 32'h7000_0001 || issued !== exp_issued) begin
      failures++;
      $display("FAIL trap_frozen got=%0h/%0h/%0h exp=1/70000001/%0h", trap, dec_inst, issued, exp_issued);
    end
    tick();
    trap_clr = 1'b0;
    #1;
    checks++;
    if (trap !== 1'b0 || dec_inst !== 32'h0 || reqd !== 1'b1 || exec_req !== 1'b0) begin
      failures++;
      $display("FAIL trap_clr got=%0h/%0h/%0h/%0h exp=0/0/1/0", trap, dec_inst, reqd, exec_req);
    end
    exec_ack = 1'b0;
    ackd     = 1'b1;
    instd    = 32'h2000_0009;
    tick();
    ackd     = 1'b0;
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    #1;
    checks++;
    if (dec_inst !== 32'h2000_0009 || exec_req !== 1'b1 || trap !== 1'b0) begin
      failures++;
      $display("FAIL clr_in_run got=%0h/%0h/%0h exp=20000009/1/0", dec_inst, exec_req, trap);
    end
    exec_ack = 1'b1;
    tick();
    exec_ack = 1'b0;
    exp_issued = exp_issued + 16'd1;
  endtask

  task automatic test_flush();
    exec_ack = 1'b0;
    ackd     = 1'b1;
    instd    = 32'h0000_00AA;
    tick();
    instd = 32'h0000_00BB;
    tick();
    instd    = 32'h0000_00CC;
    flush    = 1'b1;
    exec_ack = 1'b1;
    #1;
    checks++;
    if (reqd !== 1'b0 || exec_req !== 1'b0) begin
      failures++;
      $display("FAIL fl_cycle got=%0h/%0h exp=0/0", reqd, exec_req);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (dec_inst !== 32'h0 || issued !== exp_issued || trap !== 1'b0) begin
      failures++;
      $display("FAIL fl_after got=%0h/%0h/%0h exp=0/%0h/0", dec_inst, issued, trap, exp_issued);
    end
    checks++;
    if (reqd !== 1'b1 || exec_req !== 1'b0) begin
      failures++;
      $display("FAIL fl_reqd got=%0h/%0h exp=1/0", reqd, exec_req);
    end
    ackd  = 1'b1;
    instd = 32'hC000_0000;
    tick();
    ackd = 1'b0;
    tick();
    #1;
    checks++;
    if (trap !== 1'b1 || trap_op !== 4'hC) begin
      failures++;
      $display("FAIL fl_trap_pre got=%0h/%0h exp=1/c", trap, trap_op);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (trap !== 1'b0 || trap_op !== 4'h0 || reqd !== 1'b1 || dec_inst !== 32'h0) begin
      failures++;
      $display("FAIL fl_trap got=%0h/%0h/%0h/%0h exp=0/0/1/0", trap, trap_op, reqd, dec_inst);
    end
  endtask

  task automatic test_wrap();
    int k;
    k = 65535 - int'(exp_issued);
    exec_ack = 1'b1;
    ackd     = 1'b1;
    instd    = 32'h3000_0001;
    for (int i = 0; i < k; i++) begin
      tick();
    end
    ackd = 1'b0;
    tick();
    #1;
    checks++;
    if (issued !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_pre got=%0h exp=ffff", issued);
    end
    ackd = 1'b1;
    tick();
    ackd = 1'b0;
    tick();
    exec_ack = 1'b0;
    #1;
    checks++;
    if (issued !== 16'h0000) begin
      failures++;
      $display("FAIL wrap got=%0h exp=0", issued);
    end
    exp_issued = 16'h0;
  endtask

  task automatic test_reset_mid();
    exec_ack = 1'b0;
    ackd     = 1'b1;
    instd    = 32'h0400_0004;
    tick();
    ackd  = 1'b1;
    instd = 32'h0500_0005;
    exec_ack = 1'b1;
    flush = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (reqd !== 1'b0 || exec_req !== 1'b0) begin
      failures++;
      $display("FAIL rm_cycle got=%0h/%0h exp=0/0", reqd, exec_req);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (dec_inst !== 32'h0 || issued !== 16'h0 || trap !== 1'b0 || trap_op !== 4'h0) begin
      failures++;
      $display("FAIL rm_regs got=%0h/%0h/%0h/%0h exp=0/0/0/0", dec_inst, issued, trap, trap_op);
    end
    checks++;
    if (reqd !== 1'b1 || exec_req !== 1'b0) begin
      failures++;
      $display("FAIL rm_run got=%0h/%0h exp=1/0", reqd, exec_req);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_issued = 16'h0;
    reset      = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_trap();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hs32_dec_ctl.md
HS32_DEC_CTL -- requirements
Module: hs32_dec_ctl

Interface
REQ-001 SHALL provide parameter DEPTH, default 2, meaning instruction buffer entries (power of two, >=2).
REQ-002 SHALL provide parameter MAXOP, default 4'h4, meaning highest legal instruction prefix.
REQ-003 SHALL provide port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port instd  input  32  instruction word from fetch.
REQ-006 SHALL provide port ackd  input  1  fetch presents a valid instd this cycle.
REQ-007 SHALL provide port reqd  output  1  controller can accept an instruction this cycle.
REQ-008 SHALL provide port dec_inst  output  32  buffer head, driven to the decoder.
REQ-009 SHALL provide port exec_req  output  1  head is issuable to execute.
REQ-010 SHALL provide port exec_ack  input  1  execute accepted the head.
REQ-011 SHALL provide port flush  input  1  branch/redirect; discard all buffered work.
REQ-012 SHALL provide port trap  output  1  illegal prefix detected at head.
REQ-013 SHALL provide port trap_op  output  4  prefix that caused trap.
REQ-014 SHALL provide port trap_clr  input  1  software/exception unit acknowledges trap.
REQ-015 SHALL provide port issued  output  16  count of instructions issued to execute.

Function
REQ-016 SHALL implement a DEPTH-entry FIFO with read/write pointers and occupancy count 0..DEPTH.
REQ-017 SHALL drive reqd = (count < DEPTH) && state==RUN && !flush, combinationally.
REQ-018 SHALL push instd when reqd && ackd; a push with reqd low is ignored and never corrupts state.
REQ-019 SHALL drive dec_inst from head entry; value undefined-but-stable when count==0 (drive 32'h0).
REQ-020 SHALL drive exec_req = state==RUN && count>0 && head[31:28] <= MAXOP && !flush.
REQ-021 SHALL pop the head on exec_req && exec_ack; issued increments by 1, wrapping 16'hFFFF->16'h0000.
REQ-022 SHALL give 1-cycle minimum latency: instruction pushed in cycle N raises exec_req in cycle N+1.
REQ-023 SHALL support simultaneous push and pop: count unchanged; at count==DEPTH no push occurs since reqd is low.
REQ-024 SHALL implement states RUN and TRAP; reset enters RUN.
REQ-025 SHALL transition RUN->TRAP when count>0, head[31:28] > MAXOP, and no flush; trap=1 and trap_op=head[31:28] registered on entry.
REQ-026 SHALL hold in TRAP with reqd=0, exec_req=0, FIFO contents frozen, until trap_clr or flush.
REQ-027 SHALL on trap_clr in TRAP discard only the head entry, clear trap, return to RUN.
REQ-028 SHALL on flush (any state) set count=0, pointers=0, clear trap and trap_op, enter RUN; a same-cycle ackd is dropped and a same-cycle exec_ack does not increment issued.
REQ-029 SHALL give flush priority over trap_clr, push, pop and trap entry.
REQ-030 SHALL allow trap_clr in RUN with no effect.

Reset
REQ-031 SHALL on reset: state=RUN, count=0, pointers=0, trap=0, trap_op=4'h0, issued=16'h0, dec_inst=32'h0.
REQ-032 SHALL let reset mid-operation override flush, push and pop in the same cycle; buffered instructions are lost.
REQ-033 SHALL drive reqd=0 and exec_req=0 during the reset cycle.

Structure
REQ-034 SHALL place prefix constants (IMM16=0, SHIFT=1, IMM24=2, REG=3, JUMP=4), MAXOP default and state encoding in shared package hs32_pkg.
REQ-035 SHALL instantiate one sub-module, hs32_ibuf, holding FIFO storage, pointers and count; controller FSM and counters stay in hs32_dec_ctl.

Verification
REQ-036 SHALL verify streaming: push 32'h0123_4567, 32'h3ABC_0000 back-to-back, exec_ack always 1 -> exec_req one cycle after each push, dec_inst in order, issued=2.
REQ-037 SHALL verify backpressure: exec_ack=0, push 3 words with DEPTH=2 -> reqd low after 2 pushes, third ackd ignored, count=2.
REQ-038 SHALL verify trap: push 32'h7000_0001 -> trap=1, trap_op=4'h7, exec_req=0, reqd=0; trap_clr -> trap=0, entry discarded, RUN.
REQ-039 SHALL verify flush: count=2, flush with ackd=1 and exec_ack=1 -> count=0, issued unchanged, trap=0, next cycle reqd=1.
REQ-040 SHALL verify counter wrap: preload 65535 issues, one more issue -> issued=16'h0000.
REQ-041 SHALL verify reset mid-stream: count=1, reset with ackd=1 -> all outputs at reset values next cycle.
